// File: rtl/note_arbiter.sv
// Note source arbiter: picks key, UART or playback note for the buzzer/LED output by mode.
// Optional macro NOTE_ARBITER_ONEHOT_EN reduces every note to its lowest set note and octave bit.
module note_arbiter #(
    parameter int TICK_CYCLES     = 100000,
    parameter int UART_HOLD_TICKS = 500,
    parameter int GAP_TICKS       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [9:0] key_note,
    input  logic       uart_valid,
    input  logic [9:0] uart_note,
    input  logic       play_valid,
    input  logic [9:0] play_note,
    input  logic [15:0] play_len,
    output logic       play_ready,
    output logic [9:0] note_out,
    output logic [1:0] src,
    output logic       busy
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [15:0]   HOLD_LAST = 16'(UART_HOLD_TICKS - 1);
    localparam logic [15:0]   GAP_LAST  = 16'(GAP_TICKS - 1);

    localparam logic [1:0] M_FREE  = 2'b00;
    localparam logic [1:0] M_PLAY  = 2'b01;
    localparam logic [1:0] M_UART  = 2'b10;
    localparam logic [1:0] M_LEARN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_UART_HOLD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t         state, nxt;
    logic [1:0]     mode_q;
    logic [PW-1:0]  pre;
    logic [15:0]    ticks;
    logic [15:0]    len_q, len_nxt;
    logic [9:0]     note_nxt, note_out_nxt;
    logic [1:0]     src_nxt;
    logic [15:0]    limit;
    logic           done, restart, timed;

    function automatic logic [9:0] shape(input logic [9:0] n);
`ifdef NOTE_ARBITER_ONEHOT_EN
        logic [6:0] lo;
        logic [2:0] hi;
        lo = n[6:0] & (~n[6:0] + 7'd1);
        hi = n[9:7] & (~n[9:7] + 3'd1);
        return {hi, lo};
`else
        return n;
`endif
    endfunction

    always_comb begin
        case (state)
            S_UART_HOLD: limit = HOLD_LAST;
            S_PLAY:      limit = len_q - 16'd1;
            default:     limit = GAP_LAST;
        endcase
    end

    assign done  = (pre == PRE_LAST) && (ticks == limit);
    assign timed = (state == S_UART_HOLD) || (state == S_PLAY) || (state == S_GAP);

    always_comb begin
        nxt      = state;
        note_nxt = note_out;
        len_nxt  = len_q;
        restart  = 1'b0;
        // A mode change overrides everything; the aborted source is simply forgotten.
        if (mode != mode_q) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((mode == M_FREE || mode == M_LEARN) && |key_note[6:0]) begin
                        nxt      = S_KEY;
                        note_nxt = shape(key_note);
                    end else if (mode == M_UART && uart_valid && |uart_note[6:0]) begin
                        nxt      = S_UART_HOLD;
                        note_nxt = shape(uart_note);
                    end else if (mode == M_PLAY && play_valid && play_ready) begin
                        len_nxt = play_len;
                        if (play_len != 16'd0) begin
                            nxt      = S_PLAY;
                            note_nxt = shape(play_note);
                        end else begin
                            nxt = S_GAP;
                        end
                    end
                end
                S_KEY: begin
                    if (|key_note[6:0]) note_nxt = shape(key_note);
                    else                nxt      = S_IDLE;
                end
                S_UART_HOLD: begin
                    if (uart_valid && |uart_note[6:0]) begin
                        note_nxt = shape(uart_note);
                        restart  = 1'b1;
                    end else if (done) begin
                        nxt = S_IDLE;
                    end
                end
                S_PLAY:  if (done) nxt = S_GAP;
                S_GAP:   if (done) nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
        if (nxt != state) restart = 1'b1;
    end

    always_comb begin
        note_out_nxt = '0;
        src_nxt      = 2'b00;
        case (nxt)
            S_KEY:       begin note_out_nxt = note_nxt; src_nxt = 2'b01; end
            S_UART_HOLD: begin note_out_nxt = note_nxt; src_nxt = 2'b10; end
            S_PLAY:      begin note_out_nxt = note_nxt; src_nxt = 2'b11; end
            S_GAP:       src_nxt = 2'b11;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_q     <= '0;
            pre        <= '0;
            ticks      <= '0;
            len_q      <= '0;
            note_out   <= '0;
            src        <= '0;
            busy       <= 1'b0;
            play_ready <= 1'b0;
        end else begin
            state      <= nxt;
            mode_q     <= mode;
            len_q      <= len_nxt;
            note_out   <= note_out_nxt;
            src        <= src_nxt;
            busy       <= (nxt != S_IDLE);
            play_ready <= (nxt == S_IDLE) && (mode == M_PLAY);
            // Counters start from zero on every entry so each duration is whole ticks.
            if (restart || !timed) begin
                pre   <= '0;
                ticks <= '0;
            end else if (pre == PRE_LAST) begin
                pre   <= '0;
                ticks <= ticks + 16'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule
